// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_sync data memory.
// The parity helper is used only when RAM_PARITY_EN is defined.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Index width for a given depth; never less than one bit.
  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Even parity: the returned bit makes the total count of ones even.
  // Zero-extending narrower words to 64 bits does not change the result.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Storage for ram_sync: one shared address, one write port, a registered
// write-first read. It has no reset, so it can be inferred as iCE40 BlockRAM.
module ram_array #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2048,
  parameter int IDX_W = 11
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_sync.sv
// Single-port synchronous RAM with a self-clearing power-up sequence,
// out-of-range flagging and write-first reads. Optional macro: RAM_PARITY_EN.
module ram_sync #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  output logic [WIDTH-1:0]  out,
  output logic              busy,
  output logic              oor,
  output logic              parity_err
);
  import ram_pkg::*;

  localparam int IDX_W = idx_width(DEPTH);
`ifdef RAM_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_q, clr_d;
  logic             in_range, ready;
  logic [IDX_W-1:0] idx;
  logic             mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [SW-1:0]    mem_wdata, wr_word, rd_word;
  logic             sel_q, oor_q;

  // Compare at ADDR_W+1 bits so DEPTH == 2**ADDR_W is still handled.
  assign in_range = {1'b0, address} < DEPTH_EXT;
  assign idx      = address[IDX_W-1:0];
  assign ready    = (state_q == READY);

`ifdef RAM_PARITY_EN
  assign wr_word = {even_parity(64'(in)), in};
`else
  assign wr_word = in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_q;
        if (clr_q == LAST_IDX) begin
          state_d = READY;
          clr_d   = '0;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      READY: begin
        mem_we    = load && in_range;
        mem_addr  = in_range ? idx : '0;
        mem_wdata = wr_word;
      end
      default: state_d = CLEAR;
    endcase
  end

  ram_array #(
    .WIDTH (SW),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (rd_word)
  );

  // sel_q qualifies the array output so out is zero in reset, CLEAR and out of range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      sel_q <= ready && in_range;
      oor_q <= ready && !in_range;
    end
  end

  assign busy = (state_q == CLEAR);
  assign out  = sel_q ? rd_word[WIDTH-1:0] : '0;
  assign oor  = oor_q;

`ifdef RAM_PARITY_EN
  logic byp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_q <= 1'b0;
    end else begin
      byp_q <= ready && in_range && load;
    end
  end

  assign parity_err = sel_q && !byp_q &&
                      (rd_word[WIDTH] != even_parity(64'(rd_word[WIDTH-1:0])));
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sync.sv
// Directed self-checking bench for ram_sync: a DEPTH=16 instance and a DEPTH=2048 instance.
module tb_ram_sync;

  logic        clk = 1'b0;
  logic        rst16, rst2k;
  logic [7:0]  a16;
  logic [15:0] i16, o16;
  logic        l16, b16, oor16, pe16;
  logic [15:0] a2k, i2k, o2k;
  logic        l2k, b2k, oor2k, pe2k;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  ram_sync #(.WIDTH(16), .DEPTH(16), .ADDR_W(8)) u16 (
    .clk(clk), .reset(rst16), .address(a16), .in(i16), .load(l16),
    .out(o16), .busy(b16), .oor(oor16), .parity_err(pe16));

  ram_sync #(.WIDTH(16), .DEPTH(2048), .ADDR_W(16)) u2k (
    .clk(clk), .reset(rst2k), .address(a2k), .in(i2k), .load(l2k),
    .out(o2k), .busy(b2k), .oor(oor2k), .parity_err(pe2k));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string name, input logic [15:0] exp_out, input logic exp_oor);
    tests++;
    if (o16 !== exp_out || oor16 !== exp_oor || pe16 !== 1'b0) begin
      fails++;
      $display("FAIL %s: out=%h oor=%b perr=%b, required out=%h oor=%b perr=0",
               name, o16, oor16, pe16, exp_out, exp_oor);
    end
  endtask

  task automatic test_reset();
    rst16 = 1'b1; rst2k = 1'b1;
    a16 = '0; i16 = '0; l16 = 1'b0;
    a2k = '0; i2k = '0; l2k = 1'b0;
    step(); step();
    tests++;
    if (o16 !== 16'h0 || b16 !== 1'b1 || oor16 !== 1'b0 || pe16 !== 1'b0) begin
      fails++;
      $display("FAIL reset16: out=%h busy=%b oor=%b perr=%b, required 0000 1 0 0", o16, b16, oor16, pe16);
    end
    tests++;
    if (o2k !== 16'h0 || b2k !== 1'b1 || oor2k !== 1'b0 || pe2k !== 1'b0) begin
      fails++;
      $display("FAIL reset2k: out=%h busy=%b oor=%b perr=%b, required 0000 1 0 0", o2k, b2k, oor2k, pe2k);
    end
  endtask

  // Releases both resets, pulses load on the small instance while busy.
  task automatic test_clear();
    int c16 = 0, c2k = 0;
    logic bad = 1'b0;
    rst16 = 1'b0; rst2k = 1'b0;
    l16 = 1'b1; i16 = 16'hFFFF;
    for (int cyc = 1; cyc <= 2100; cyc++) begin
      a16 = 8'(cyc % 16);
      step();
      if (b16 && (o16 !== 16'h0 || oor16 !== 1'b0)) bad = 1'b1;
      if (!b16 && c16 == 0) begin c16 = cyc; l16 = 1'b0; end
      if (!b2k && c2k == 0) c2k = cyc;
      if (c16 != 0 && c2k != 0) break;
    end
    l16 = 1'b0;
    tests++;
    if (c16 != 16) begin fails++; $display("FAIL clear16_len: busy cycles=%0d, required 16", c16); end
    tests++;
    if (c2k != 2048) begin fails++; $display("FAIL clear2k_len: busy cycles=%0d, required 2048", c2k); end
    tests++;
    if (bad) begin fails++; $display("FAIL clear_outputs: out/oor nonzero while busy, required 0"); end
    for (int a = 0; a < 16; a++) begin
      a16 = 8'(a);
      step();
      chk16($sformatf("clear_read_%0d", a), 16'h0, 1'b0);
    end
  endtask

  task automatic test_write_read();
    a16 = 8'd5; i16 = 16'hBEEF; l16 = 1'b1;
    step(); chk16("wr5_bypass", 16'hBEEF, 1'b0);
    l16 = 1'b0; i16 = 16'h0;
    step(); chk16("rd5", 16'hBEEF, 1'b0);
    a16 = 8'd6;
    step(); chk16("rd6", 16'h0000, 1'b0);
  endtask

  task automatic test_read_during_write();
    a16 = 8'd3; i16 = 16'h1234; l16 = 1'b1;
    step(); chk16("rdw3", 16'h1234, 1'b0);
    l16 = 1'b0; i16 = 16'h0;
    step(); chk16("rd3", 16'h1234, 1'b0);
  endtask

  task automatic test_back_to_back();
    a16 = 8'd7; l16 = 1'b1;
    i16 = 16'h1111; step(); chk16("b2b_1", 16'h1111, 1'b0);
    i16 = 16'h2222; step(); chk16("b2b_2", 16'h2222, 1'b0);
    i16 = 16'h3333; step(); chk16("b2b_3", 16'h3333, 1'b0);
    l16 = 1'b0; i16 = 16'h0;
    step(); chk16("b2b_rd", 16'h3333, 1'b0);
    a16 = 8'd15; i16 = 16'h7777; l16 = 1'b1;
    step(); chk16("wr15", 16'h7777, 1'b0);
    l16 = 1'b0;
    step(); chk16("rd15", 16'h7777, 1'b0);
  endtask

  task automatic test_oor16();
    a16 = 8'd21; i16 = 16'hDEAD; l16 = 1'b1;
    step(); chk16("oor16_wr", 16'h0, 1'b1);
    l16 = 1'b0; a16 = 8'd16;
    step(); chk16("oor16_rd16", 16'h0, 1'b1);
    a16 = 8'd5;
    step(); chk16("oor16_noalias", 16'hBEEF, 1'b0);
  endtask

  task automatic test_oor2k();
    a2k = 16'd2048; i2k = 16'hAAAA; l2k = 1'b1;
    step();
    tests++;
    if (o2k !== 16'h0 || oor2k !== 1'b1) begin
      fails++; $display("FAIL oor2k_wr: out=%h oor=%b, required 0000 1", o2k, oor2k);
    end
    l2k = 1'b0; a2k = 16'd0;
    step();
    tests++;
    if (o2k !== 16'h0 || oor2k !== 1'b0 || pe2k !== 1'b0) begin
      fails++; $display("FAIL oor2k_noalias: out=%h oor=%b perr=%b, required 0000 0 0", o2k, oor2k, pe2k);
    end
    a2k = 16'd2047; i2k = 16'h5555; l2k = 1'b1;
    step(); l2k = 1'b0;
    step();
    tests++;
    if (o2k !== 16'h5555 || oor2k !== 1'b0) begin
      fails++; $display("FAIL rd2047: out=%h oor=%b, required 5555 0", o2k, oor2k);
    end
    a2k = 16'hFFFF;
    step();
    tests++;
    if (o2k !== 16'h0 || oor2k !== 1'b1) begin
      fails++; $display("FAIL oor2k_ffff: out=%h oor=%b, required 0000 1", o2k, oor2k);
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt = 0;
    rst16 = 1'b1; step(); rst16 = 1'b0;
    for (int k = 0; k < 8; k++) step();
    tests++;
    if (b16 !== 1'b1) begin fails++; $display("FAIL midclear_busy8: busy=%b, required 1", b16); end
    rst16 = 1'b1; step(); step(); rst16 = 1'b0;
    l16 = 1'b1; i16 = 16'hFFFF;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      a16 = 8'(15 - (cyc % 16));
      step();
      if (!b16) begin cnt = cyc; break; end
    end
    l16 = 1'b0; i16 = 16'h0;
    tests++;
    if (cnt != 16) begin fails++; $display("FAIL midclear_len: busy cycles=%0d, required 16", cnt); end
    a16 = 8'd3;  step(); chk16("midclear_rd3", 16'h0, 1'b0);
    a16 = 8'd5;  step(); chk16("midclear_rd5", 16'h0, 1'b0);
    a16 = 8'd15; step(); chk16("midclear_rd15", 16'h0, 1'b0);
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity();
    a16 = 8'd9; i16 = 16'h0001; l16 = 1'b1;
    step(); l16 = 1'b0;
    tests++;
    if (pe16 !== 1'b0 || o16 !== 16'h0001) begin
      fails++; $display("FAIL par_bypass: out=%h perr=%b, required 0001 0", o16, pe16);
    end
    u16.u_array.mem[9] = 17'h10000;
    step();
    tests++;
    if (o16 !== 16'h0000 || pe16 !== 1'b1) begin
      fails++; $display("FAIL par_err: out=%h perr=%b, required 0000 1", o16, pe16);
    end
    a16 = 8'd8;
    step();
    tests++;
    if (o16 !== 16'h0000 || pe16 !== 1'b0) begin
      fails++; $display("FAIL par_ok: out=%h perr=%b, required 0000 0", o16, pe16);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clear();
    test_write_read();
    test_read_during_write();
    test_back_to_back();
    test_oor16();
    test_oor2k();
    test_reset_mid_clear();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
